// File: rtl/booth_sched_if.sv
// Request/response and multiplier-side signal bundle for booth_sched.
// The slave modport is the scheduler's view; master is the environment's view.
interface booth_sched_if #(
  parameter int NREQ = 4,
  parameter int N    = 4
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] im_bus;
  logic [NREQ*N-1:0] iq_bus;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              rsp_vld;
  logic [IW-1:0]     rsp_id;
  logic [2*N-1:0]    rsp_p;
  logic              rsp_err;
  logic              m_rst;
  logic [N-1:0]      m_im;
  logic [N-1:0]      m_iq;
  logic              m_pd;
  logic [2*N-1:0]    m_p;

  modport slave (
    input  req, im_bus, iq_bus, m_pd, m_p,
    output gnt, busy, rsp_vld, rsp_id, rsp_p, rsp_err, m_rst, m_im, m_iq
  );

  modport master (
    output req, im_bus, iq_bus, m_pd, m_p,
    input  gnt, busy, rsp_vld, rsp_id, rsp_p, rsp_err, m_rst, m_im, m_iq
  );
endinterface

// File: rtl/booth_sched.sv
// Round-robin scheduler sharing one booth multiplier between NREQ requesters,
// with a done-timeout that returns an error response instead of hanging.
module booth_sched #(
  parameter int NREQ = 4,
  parameter int N    = 4,
  parameter int TMO  = 31
) (
  input  logic         clk,
  input  logic         rst,
  booth_sched_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam logic [7:0] TMO_CNT = 8'(TMO);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic [IW-1:0]   last_id;
  logic [IW-1:0]   cur_id;
  logic [IW-1:0]   win;
  logic [NREQ-1:0] win_onehot;
  logic [N-1:0]    win_im;
  logic [N-1:0]    win_iq;
  logic [7:0]      timer;
  logic [7:0]      timer_nxt;

  // Scan from last+NREQ down to last+1 so the nearest requester after last wins.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   last);
    logic [IW-1:0] pick;
    logic [IW:0]   s;
    pick = last;
    for (int k = NREQ; k >= 1; k--) begin
      s = {1'b0, last} + (IW+1)'(k);
      s = (s >= (IW+1)'(NREQ)) ? (s - (IW+1)'(NREQ)) : s;
      pick = r[s[IW-1:0]] ? s[IW-1:0] : pick;
    end
    return pick;
  endfunction

  // Winner selection and operand steering for the next grant.
  always_comb begin
    win        = rr_pick(bus.req, last_id);
    win_onehot = {NREQ{1'b0}};
    win_im     = {N{1'b0}};
    win_iq     = {N{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      win_onehot[k] = (win == IW'(k));
      win_im        = (win == IW'(k)) ? bus.im_bus[k*N +: N] : win_im;
      win_iq        = (win == IW'(k)) ? bus.iq_bus[k*N +: N] : win_iq;
    end
    timer_nxt = timer + 8'd1;
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_id     <= IW'(NREQ-1);
      cur_id      <= {IW{1'b0}};
      timer       <= 8'd0;
      bus.gnt     <= {NREQ{1'b0}};
      bus.busy    <= 1'b0;
      bus.rsp_vld <= 1'b0;
      bus.rsp_id  <= {IW{1'b0}};
      bus.rsp_p   <= {(2*N){1'b0}};
      bus.rsp_err <= 1'b0;
      bus.m_rst   <= 1'b1;
      bus.m_im    <= {N{1'b0}};
      bus.m_iq    <= {N{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state     <= LOAD;
            bus.gnt   <= win_onehot;
            bus.m_im  <= win_im;
            bus.m_iq  <= win_iq;
            cur_id    <= win;
            bus.m_rst <= 1'b0;
            bus.busy  <= 1'b1;
          end
        end
        LOAD: begin
          state     <= WAIT;
          bus.gnt   <= {NREQ{1'b0}};
          bus.m_rst <= 1'b1;
          timer     <= 8'd0;
        end
        WAIT: begin
          timer <= timer_nxt;
          // A done seen while timer is still 0 may be left over from the previous job.
          if ((timer != 8'd0) && bus.m_pd) begin
            state       <= DONE;
            bus.rsp_p   <= bus.m_p;
            bus.rsp_err <= 1'b0;
            bus.rsp_vld <= 1'b1;
            bus.rsp_id  <= cur_id;
          end else if (timer_nxt == TMO_CNT) begin
            state       <= DONE;
            bus.rsp_p   <= {(2*N){1'b0}};
            bus.rsp_err <= 1'b1;
            bus.rsp_vld <= 1'b1;
            bus.rsp_id  <= cur_id;
          end
        end
        DONE: begin
          state       <= IDLE;
          bus.rsp_vld <= 1'b0;
          bus.busy    <= 1'b0;
          last_id     <= cur_id;
        end
        default: begin
          state       <= IDLE;
          bus.gnt     <= {NREQ{1'b0}};
          bus.busy    <= 1'b0;
          bus.rsp_vld <= 1'b0;
          bus.m_rst   <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_booth_sched.sv
// Self-checking bench for booth_sched: directed vector table, hand-written
// reset/priority sequences, exhaustive operand sweep and randomized traffic.
module tb_booth_sched;
  localparam int NREQ = 4;
  localparam int N    = 4;
  localparam int TMO  = 31;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   model_last;

  booth_sched_if #(.NREQ(NREQ), .N(N)) bus ();

  booth_sched #(.NREQ(NREQ), .N(N), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] im;
    logic [3:0] iq;
    int         lat;
    bit         stale;
    int         id;
    bit         err;
    logic [7:0] p;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural reference: nearest requester after the last served one, with wrap.
  function automatic int model_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
    int x;
    int y;
    x = $signed(a);
    y = $signed(b);
    return 8'(x * y);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},     32'(bus.gnt),     32'd0);
    check({tag, "_busy"},    32'(bus.busy),    32'd0);
    check({tag, "_rsp_vld"}, 32'(bus.rsp_vld), 32'd0);
    check({tag, "_rsp_id"},  32'(bus.rsp_id),  32'd0);
    check({tag, "_rsp_p"},   32'(bus.rsp_p),   32'd0);
    check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    check({tag, "_m_rst"},   32'(bus.m_rst),   32'd1);
    check({tag, "_m_im"},    32'(bus.m_im),    32'd0);
    check({tag, "_m_iq"},    32'(bus.m_iq),    32'd0);
  endtask

  // One transaction; starts and ends on a negedge. The environment's multiplier
  // raises m_pd only in WAIT cycle 'lat' (and in WAIT cycle 1 when 'stale').
  task automatic do_op(input logic [3:0] r, input logic [3:0] a, input logic [3:0] b,
                       input int lat, input bit stale, input bit keep,
                       input int eid, input bit eerr, input logic [7:0] ep);
    int n;
    int w;
    int ew;
    logic [7:0]  prod;
    logic [15:0] imv;
    logic [15:0] iqv;
    imv = 16'($urandom);
    iqv = 16'($urandom);
    imv[eid*N +: N] = a;
    iqv[eid*N +: N] = b;
    bus.im_bus = imv;
    bus.iq_bus = iqv;
    bus.req    = r;
    prod       = ref_mul(a, b);
    n = 0;
    @(negedge clk);
    while (bus.gnt == 4'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      check("grant_timeout", 32'(n), 32'd0);
      return;
    end
    check("gnt",        32'(bus.gnt),   32'(4'd1 << eid));
    check("load_m_rst", 32'(bus.m_rst), 32'd0);
    check("load_busy",  32'(bus.busy),  32'd1);
    check("m_im",       32'(bus.m_im),  32'(a));
    check("m_iq",       32'(bus.m_iq),  32'(b));
    if (!keep) bus.req[eid] = 1'b0;
    w = 0;
    forever begin
      @(negedge clk);
      if (bus.rsp_vld || w >= 300) break;
      w++;
      if (w == 1) begin
        check("wait_gnt",   32'(bus.gnt),   32'd0);
        check("wait_m_rst", 32'(bus.m_rst), 32'd1);
      end
      bus.m_pd = (w == lat) || (stale && w == 1);
      bus.m_p  = (w == lat) ? prod : 8'($urandom);
    end
    bus.m_pd = 1'b0;
    ew = (lat >= 2 && lat <= TMO) ? lat : TMO;
    check("rsp_vld",     32'(bus.rsp_vld), 32'd1);
    check("wait_cycles", 32'(w),           32'(ew));
    check("rsp_id",      32'(bus.rsp_id),  32'(eid));
    check("rsp_err",     32'(bus.rsp_err), 32'(eerr));
    check("rsp_p",       32'(bus.rsp_p),   32'(ep));
    @(negedge clk);
    check("vld_pulse",   32'(bus.rsp_vld), 32'd0);
    check("idle_busy",   32'(bus.busy),    32'd0);
    check("rsp_p_hold",  32'(bus.rsp_p),   32'(ep));
    model_last = eid;
  endtask

  initial begin
    int n;
    int eid;
    int lat;
    bit stale;
    bit eerr;
    logic [3:0] r;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] ep;
    logic [7:0] ab;

    checks = 0;
    errors = 0;
    model_last = NREQ - 1;
    bus.req = 4'd0; bus.im_bus = 16'd0; bus.iq_bus = 16'd0;
    bus.m_pd = 1'b0; bus.m_p = 8'd0;

    tbl[0] = '{4'b0001, 4'd3,  4'hE, 3,       1'b0, 0, 1'b0, 8'hFA};
    tbl[1] = '{4'b0010, 4'd7,  4'd7, 2,       1'b0, 1, 1'b0, 8'h31};
    tbl[2] = '{4'b1010, 4'h8,  4'h8, 4,       1'b0, 3, 1'b0, 8'h40};
    tbl[3] = '{4'b0010, 4'h8,  4'd7, 6,       1'b0, 1, 1'b0, 8'hC8};
    tbl[4] = '{4'b0101, 4'd5,  4'd3, 0,       1'b0, 2, 1'b1, 8'h00};
    tbl[5] = '{4'b0001, 4'd2,  4'd5, 5,       1'b1, 0, 1'b0, 8'h0A};
    tbl[6] = '{4'b1111, 4'hF,  4'hF, TMO,     1'b0, 1, 1'b0, 8'h01};
    tbl[7] = '{4'b1101, 4'd4,  4'd4, TMO + 1, 1'b0, 2, 1'b1, 8'h00};
    tbl[8] = '{4'b1000, 4'd1,  4'd1, 1,       1'b0, 3, 1'b1, 8'h00};

    // Reset state, with requests present that must not be granted.
    rst = 1'b0;
    bus.req = 4'b1111;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    bus.req = 4'b0000;
    @(negedge clk);

    foreach (tbl[i]) begin
      do_op(tbl[i].req, tbl[i].im, tbl[i].iq, tbl[i].lat, tbl[i].stale, 1'b0,
            tbl[i].id, tbl[i].err, tbl[i].p);
    end

    // Requests held at 1111 after a reset: grants rotate 0,1,2,3,0.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_last = NREQ - 1;
    bus.req = 4'b0000;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      do_op(4'b1111, a, b, 2 + i, 1'b0, 1'b1, i % NREQ, 1'b0, ref_mul(a, b));
    end
    bus.req = 4'b0000;
    @(negedge clk);

    // Reset pulsed during WAIT: outputs clear, no response, priority restarts at 0.
    bus.req = 4'b0100;
    n = 0;
    @(negedge clk);
    while (bus.gnt == 4'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rstwait_gnt", 32'(bus.gnt), 32'b0100);
    bus.req = 4'b0000;
    repeat (3) @(negedge clk);
    check("rstwait_busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b1;
    model_last = NREQ - 1;
    repeat (2) begin
      @(negedge clk);
      check("post_reset_no_vld", 32'(bus.rsp_vld), 32'd0);
    end
    do_op(4'b0101, 4'd6, 4'd2, 3, 1'b0, 1'b0, 0, 1'b0, 8'h0C);

    // Every signed operand pair through requester 2.
    for (int i = 0; i < 256; i++) begin
      ab = 8'(i);
      a  = ab[7:4];
      b  = ab[3:0];
      do_op(4'b0100, a, b, int'($urandom_range(2, 6)), 1'b0, 1'b0, 2, 1'b0, ref_mul(a, b));
    end

    // Randomized requests, latencies and stale dones against the reference model.
    for (int i = 0; i < 40; i++) begin
      r     = 4'($urandom_range(1, 15));
      eid   = model_pick(r, model_last);
      a     = 4'($urandom);
      b     = 4'($urandom);
      lat   = int'($urandom_range(0, TMO + 2));
      stale = 1'($urandom);
      eerr  = !(lat >= 2 && lat <= TMO);
      ep    = eerr ? 8'h00 : ref_mul(a, b);
      do_op(r, a, b, lat, stale, 1'b0, eid, eerr, ep);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
